dds_cfg_ctrl: RTL

Configuration controller for the DDS wave generator: turns single-cycle key pulses (wave select, frequency up/down, amplitude) into a shadowed configuration. It commits that configuration to the DDS phase accumulator and wave LUT only at a phase-accumulator wrap, or after a timeout, so the output never glitches mid-period. It sits between the key debounce/pulse logic and the DDS core.

---
 rtl/dds_ctrl_pkg.sv | 17 +
 rtl/commit_timer.sv | 28 ++
 rtl/dds_cfg_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dds_ctrl_pkg.sv
// rtl/dds_ctrl_pkg.sv - shared types and constants for the DDS configuration controller
package dds_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] WAVE_SINE   = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SAW    = 2'd3;

  localparam logic [31:0] DEFAULT_BASE_WORD = 32'd85899;

endpackage

// File: rtl/commit_timer.sv
// rtl/commit_timer.sv - ARMED-state timeout counter; expired on the last cycle before a forced commit
module commit_timer #(
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);

  logic [CW-1:0] r_cnt;

  assign expired = (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && !expired) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dds_cfg_ctrl.sv
// rtl/dds_cfg_ctrl.sv - shadowed DDS configuration, committed on phase wrap or timeout
module dds_cfg_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_WORD   = DEFAULT_BASE_WORD,
  parameter int          FW          = 32,
  parameter int          MAX_IDX     = 7,
  parameter int          TIMEOUT_CYC = 50_000_000
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          key_wave,
  input  logic          key_freq_up,
  input  logic          key_freq_dn,
  input  logic          key_amp,
  input  logic          phase_wrap,
  output logic [1:0]    wave_sel,
  output logic [FW-1:0] freq_word,
  output logic [1:0]    amp_shift,
  output logic          cfg_update,
  output logic          pending
);

  localparam int            IW      = (MAX_IDX < 1) ? 1 : $clog2(MAX_IDX + 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(MAX_IDX);

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_sh_wave, r_sh_amp, r_act_wave, r_act_amp;
  logic [IW-1:0] r_sh_idx, r_act_idx;
  logic [FW-1:0] r_freq_word;
  logic          r_cfg_update, r_pending;

  logic [1:0]    w_sh_wave_nxt, w_sh_amp_nxt;
  logic [IW-1:0] w_sh_idx_nxt;
  logic [FW-1:0] w_freq_word_nxt;
  logic          w_diff_act, w_diff_sh;
  logic          w_commit, w_timer_clr, w_timer_en, w_expired;

  assign w_sh_wave_nxt = key_wave ? (r_sh_wave + 2'd1) : r_sh_wave;
  assign w_sh_amp_nxt  = key_amp  ? (r_sh_amp  + 2'd1) : r_sh_amp;

  // Simultaneous up and down cancel; each direction saturates at its end.
  always_comb begin
    w_sh_idx_nxt = r_sh_idx;
    if (key_freq_up && !key_freq_dn && (r_sh_idx != IDX_MAX)) begin
      w_sh_idx_nxt = r_sh_idx + IW'(1);
    end else if (key_freq_dn && !key_freq_up && (r_sh_idx != '0)) begin
      w_sh_idx_nxt = r_sh_idx - IW'(1);
    end
  end

  // Post-key shadow vs. the active set (IDLE/ARMED) and vs. the value being committed (COMMIT).
  assign w_diff_act = {w_sh_wave_nxt, w_sh_idx_nxt, w_sh_amp_nxt} != {r_act_wave, r_act_idx, r_act_amp};
  assign w_diff_sh  = {w_sh_wave_nxt, w_sh_idx_nxt, w_sh_amp_nxt} != {r_sh_wave, r_sh_idx, r_sh_amp};

  assign w_freq_word_nxt = FW'(BASE_WORD) << r_sh_idx;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_diff_act) w_state_nxt = ARMED;
      ARMED: begin
        if (phase_wrap || w_expired) w_state_nxt = COMMIT;
        else if (!w_diff_act)        w_state_nxt = IDLE;
      end
      COMMIT:  w_state_nxt = w_diff_sh ? ARMED : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_commit    = (r_state == COMMIT);
    w_timer_en  = (r_state == ARMED);
    w_timer_clr = (r_state != ARMED);
  end

  commit_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_commit_timer (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (w_timer_clr),
    .en        (w_timer_en),
    .expired   (w_expired)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sh_wave    <= WAVE_SINE;
      r_sh_idx     <= '0;
      r_sh_amp     <= 2'd0;
      r_act_wave   <= WAVE_SINE;
      r_act_idx    <= '0;
      r_act_amp    <= 2'd0;
      r_freq_word  <= FW'(BASE_WORD);
      r_cfg_update <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      r_sh_wave    <= w_sh_wave_nxt;
      r_sh_idx     <= w_sh_idx_nxt;
      r_sh_amp     <= w_sh_amp_nxt;
      r_cfg_update <= w_commit;
      r_pending    <= (w_state_nxt != IDLE);
      if (w_commit) begin
        r_act_wave  <= r_sh_wave;
        r_act_idx   <= r_sh_idx;
        r_act_amp   <= r_sh_amp;
        r_freq_word <= w_freq_word_nxt;
      end
    end
  end

  assign wave_sel   = r_act_wave;
  assign freq_word  = r_freq_word;
  assign amp_shift  = r_act_amp;
  assign cfg_update = r_cfg_update;
  assign pending    = r_pending;

endmodule
